// File: rtl/binary_to_bcd_pkg.sv
// Shared sizing helpers and state type for the binary-to-BCD converter.
// Pure elaboration-time functions; nothing here generates logic.
package bcd_pkg;

   localparam int MAX_BIN_W = 32;

   typedef enum logic {IDLE, CONV} state_e;

   function automatic int bcd_width(input int digits);
      return 4 * digits;
   endfunction

   function automatic longint unsigned max_bcd(input int digits);
      longint unsigned p;
      p = 1;
      for (int i = 0; i < digits; i++) p = p * 10;
      return p - 1;
   endfunction

   // Digits needed so a full-range BIN_W input never spills out of the accumulator.
   function automatic int acc_digits(input int bin_w, input int digits);
      longint unsigned maxv;
      longint unsigned p;
      int d;
      maxv = (64'd1 << bin_w) - 64'd1;
      p = 10;
      d = 1;
      while (p <= maxv) begin
         p = p * 10;
         d = d + 1;
      end
      return (d > digits) ? d : digits;
   endfunction

endpackage

// File: rtl/binary_to_bcd_if.sv
// Request/result bundle between a client and the converter.
// master drives start/bin_in; slave (the converter) drives status and result.
interface binary_to_bcd_if #(
   parameter int BIN_W  = 12,
   parameter int DIGITS = 3
);
   logic                  start;
   logic [BIN_W-1:0]      bin_in;
   logic                  busy;
   logic                  done;
   logic                  overflow;
   logic [4*DIGITS-1:0]   bcd_out;

   modport master (output start, bin_in, input busy, done, overflow, bcd_out);
   modport slave  (input start, bin_in, output busy, done, overflow, bcd_out);
endinterface

// File: rtl/binary_to_bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more.
// Purely combinational.
module bcd_digit_adj (
   input  logic [3:0] digit_i,
   output logic [3:0] digit_o
);
   assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;
endmodule

// File: rtl/binary_to_bcd.sv
// Iterative shift-add-3 binary to BCD converter, saturating to all 9s on overflow.
// Latency BIN_W clocks from accepting edge to done; start ignored while busy.
module binary_to_bcd
   import bcd_pkg::*;
#(
   parameter int BIN_W  = 12,
   parameter int DIGITS = 3
) (
   input  logic clk,
   input  logic reset,
   binary_to_bcd_if.slave bus
);
   localparam int BCD_W = bcd_width(DIGITS);
   localparam int ACC_D = acc_digits(BIN_W, DIGITS);
   localparam int ACC_W = bcd_width(ACC_D);
   localparam int CNT_W = $clog2(BIN_W + 1);
   localparam longint unsigned MAX_VAL = max_bcd(DIGITS);

   if (BIN_W < 1 || BIN_W > MAX_BIN_W) begin : g_bad_bin_w
      $error("binary_to_bcd: BIN_W out of range");
   end

   state_e             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [BIN_W-1:0]   bin_q;
   logic [BIN_W-1:0]   bin_d;
   logic [ACC_W-1:0]   acc_q;
   logic [ACC_W-1:0]   acc_adj;
   logic [ACC_W-1:0]   acc_d;
   logic               ovf_pend_q;
   logic               done_q;
   logic               ovf_q;
   logic [BCD_W-1:0]   bcd_q;

   for (genvar g = 0; g < ACC_D; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .digit_i (acc_q[4*g +: 4]),
         .digit_o (acc_adj[4*g +: 4])
      );
   end

   assign {acc_d, bin_d} = {acc_adj, bin_q} << 1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         bin_q      <= '0;
         acc_q      <= '0;
         ovf_pend_q <= 1'b0;
         done_q     <= 1'b0;
         ovf_q      <= 1'b0;
         bcd_q      <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  bin_q      <= bus.bin_in;
                  acc_q      <= '0;
                  cnt_q      <= '0;
                  ovf_pend_q <= 64'(bus.bin_in) > MAX_VAL;
                  state_q    <= CONV;
               end
            end
            CONV: begin
               acc_q <= acc_d;
               bin_q <= bin_d;
               cnt_q <= cnt_q + 1'b1;
               // The final shift is taken straight from acc_d so done lands on the BIN_W-th edge.
               if (cnt_q == CNT_W'(BIN_W - 1)) begin
                  state_q <= IDLE;
                  done_q  <= 1'b1;
                  ovf_q   <= ovf_pend_q;
                  bcd_q   <= ovf_pend_q ? {DIGITS{4'h9}} : acc_d[BCD_W-1:0];
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.busy     = (state_q == CONV);
   assign bus.done     = done_q;
   assign bus.overflow = ovf_q;
   assign bus.bcd_out  = bcd_q;

endmodule

// File: tb/tb_binary_to_bcd.sv
// Randomised bench for binary_to_bcd against a cycle-level reference model.
module tb_binary_to_bcd;
   localparam int BIN_W  = 12;
   localparam int DIGITS = 3;
   localparam int MAXV   = 10**DIGITS - 1;
   localparam int BINMAX = 2**BIN_W - 1;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   binary_to_bcd_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

   binary_to_bcd #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference state: cycles of conversion remaining and the last published result.
   int                  rem;
   int                  pend;
   logic                exp_done;
   logic                exp_ovf;
   logic [4*DIGITS-1:0] exp_bcd;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   function automatic logic [4*DIGITS-1:0] ref_bcd(input int v);
      logic [4*DIGITS-1:0] r;
      int p;
      if (v > MAXV) return {DIGITS{4'h9}};
      r = '0;
      p = v;
      for (int d = 0; d < DIGITS; d++) begin
         r[4*d +: 4] = 4'(p % 10);
         p = p / 10;
      end
      return r;
   endfunction

   task automatic step(input logic s, input int b, input logic r);
      bus.start  = s;
      bus.bin_in = BIN_W'(b);
      reset      = r;
      @(posedge clk);
      #1;
      exp_done = 1'b0;
      if (r) begin
         rem     = 0;
         exp_ovf = 1'b0;
         exp_bcd = '0;
      end else if (rem == 0) begin
         if (s) begin
            pend = b;
            rem  = BIN_W;
         end
      end else begin
         rem = rem - 1;
         if (rem == 0) begin
            exp_done = 1'b1;
            exp_ovf  = (pend > MAXV);
            exp_bcd  = ref_bcd(pend);
         end
      end
      check_eq("busy", 64'(bus.busy), 64'(rem != 0));
      check_eq("done", 64'(bus.done), 64'(exp_done));
      check_eq("overflow", 64'(bus.overflow), 64'(exp_ovf));
      check_eq("bcd_out", 64'(bus.bcd_out), 64'(exp_bcd));
   endtask

   // One accepted conversion; optionally pulse start with junk data while busy.
   task automatic convert(input int v, input bit noisy);
      step(1'b1, v, 1'b0);
      for (int i = 0; i < BIN_W; i++) begin
         if (noisy) step(1'($urandom_range(0, 1)), int'($urandom_range(0, BINMAX)), 1'b0);
         else       step(1'b0, int'($urandom_range(0, BINMAX)), 1'b0);
      end
   endtask

   int dir_vals [8] = '{59, 999, 0, 7, 1000, 4095, 998, 500};
   int done_seen;
   int last_done;

   initial begin
      checks     = 0;
      errors     = 0;
      rem        = 0;
      pend       = 0;
      exp_done   = 1'b0;
      exp_ovf    = 1'b0;
      exp_bcd    = '0;
      reset      = 1'b1;
      bus.start  = 1'b0;
      bus.bin_in = '0;

      step(1'b0, 0, 1'b1);
      step(1'b1, 123, 1'b1);
      step(1'b0, 0, 1'b0);

      foreach (dir_vals[i]) convert(dir_vals[i], 1'b0);
      repeat (3) step(1'b0, 0, 1'b0);

      for (int i = 0; i < 6; i++) convert(int'($urandom_range(0, BINMAX)), 1'b1);
      repeat (2) step(1'b0, 0, 1'b0);

      // Reset after five iterations: the conversion must vanish without a done.
      step(1'b1, 842, 1'b0);
      repeat (5) step(1'b0, 0, 1'b0);
      step(1'b0, 0, 1'b1);
      repeat (20) step(1'b0, 0, 1'b0);
      convert(371, 1'b0);

      // Start held high: expect a done every BIN_W+1 clocks.
      done_seen = 0;
      last_done = -1;
      for (int c = 0; c < 6 * (BIN_W + 1); c++) begin
         step(1'b1, int'($urandom_range(0, BINMAX)), 1'b0);
         if (bus.done) begin
            if (last_done >= 0) check_eq("b2b_period", 64'(c - last_done), 64'(BIN_W + 1));
            last_done = c;
            done_seen++;
         end
      end
      check_eq("b2b_count", 64'(done_seen >= 5), 64'(1));
      repeat (BIN_W + 2) step(1'b0, 0, 1'b0);

      for (int c = 0; c < 400; c++) begin
         step(1'($urandom_range(0, 3) == 0),
              ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, MAXV)) : int'($urandom_range(0, BINMAX)),
              1'($urandom_range(0, 99) == 0));
      end
      repeat (BIN_W + 2) step(1'b0, 0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
